mult_div_unit: RTL and testbench



---
 rtl/mult_div_unit.sv | 169 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the MIPS HI/LO register pair (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
// Define MULT_DIV_DIV_EN to build the restoring divider; without it DIV/DIVU only raise div_zero.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);
    localparam int               CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t state, state_nxt;

    // op[2]=0 selects MULT/MULTU/DIV/DIVU; op[1] picks divide, op[0] picks unsigned.
    logic op_is_div, op_signed, accept, mt_write;
    assign op_is_div = op[1];
    assign op_signed = ~op[0];
    assign accept    = (state == IDLE) && start && !op[2];
    assign mt_write  = (state == IDLE) && start && op[2] && !op[1];

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    assign a_neg = op_signed && a[WIDTH-1];
    assign b_neg = op_signed && b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] prod;
    logic               neg_res;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, opnd & {WIDTH{prod[0]}}};

`ifdef MULT_DIV_DIV_EN
    // Divide reuses prod[WIDTH-1:0]: dividend bits shift out of the top as quotient bits shift in.
    logic             is_div, neg_rem, b_zero;
    logic [WIDTH-1:0] rem, rem_diff;
    logic [WIDTH:0]   rem_shift;
    logic             rem_ge;
    assign rem_shift = {rem, prod[WIDTH-1]};
    assign rem_ge    = rem_shift >= {1'b0, opnd};
    assign rem_diff  = rem_shift[WIDTH-1:0] - opnd;
`else
    logic div_pend;
`endif

    // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
`ifdef MULT_DIV_DIV_EN
                    state_nxt = CALC;
`else
                    if (!op_is_div) state_nxt = CALC;
`endif
                end
            end
            CALC:    if (cnt == LAST) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // NOTE: the working datapath has no reset; it is always loaded at the accepting edge before use.
    always_ff @(posedge clk) begin
        if (accept) begin
`ifdef MULT_DIV_DIV_EN
            opnd    <= op_is_div ? b_mag : a_mag;
            prod    <= {{WIDTH{1'b0}}, op_is_div ? a_mag : b_mag};
            is_div  <= op_is_div;
            neg_rem <= a_neg;
            b_zero  <= (b == '0);
            rem     <= '0;
`else
            opnd    <= a_mag;
            prod    <= {{WIDTH{1'b0}}, b_mag};
`endif
            neg_res <= a_neg ^ b_neg;
            cnt     <= '0;
        end else if (state == CALC) begin
            cnt <= cnt + 1'b1;
`ifdef MULT_DIV_DIV_EN
            if (is_div) begin
                rem             <= rem_ge ? rem_diff : rem_shift[WIDTH-1:0];
                prod[WIDTH-1:0] <= {prod[WIDTH-2:0], rem_ge};
            end else begin
                prod <= {mul_sum, prod[WIDTH-1:1]};
            end
`else
            prod <= {mul_sum, prod[WIDTH-1:1]};
`endif
        end
    end

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   hi_res, lo_res;
    always_comb begin
        prod_fix = neg_res ? -prod : prod;
        hi_res   = prod_fix[2*WIDTH-1:WIDTH];
        lo_res   = prod_fix[WIDTH-1:0];
`ifdef MULT_DIV_DIV_EN
        if (is_div) begin
            // Remainder follows the dividend's sign; a zero divisor forces an all-ones quotient.
            hi_res = neg_rem ? -rem : rem;
            lo_res = b_zero ? '1 : prod_fix[WIDTH-1:0];
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
`ifndef MULT_DIV_DIV_EN
            div_pend <= 1'b0;
`endif
        end else begin
            if (mt_write) begin
                if (op[0]) lo <= a;
                else       hi <= a;
            end
`ifdef MULT_DIV_DIV_EN
            done <= (state == FIX);
            if (accept) div_zero <= 1'b0;
            if (state == FIX) begin
                hi       <= hi_res;
                lo       <= lo_res;
                div_zero <= is_div && b_zero;
            end
`else
            // Unsupported divides flag div_zero at once and pulse done one edge later.
            div_pend <= accept && op_is_div;
            done     <= (state == FIX) || div_pend;
            if (accept) div_zero <= op_is_div;
            if (state == FIX) begin
                hi <= hi_res;
                lo <= lo_res;
            end
`endif
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit; divide checks follow MULT_DIV_DIV_EN.
module tb_mult_div_unit;
    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic         clk = 1'b0;
    logic         rst_n, start;
    logic [2:0]   op;
    logic [W-1:0] a, b, hi, lo;
    logic         busy, done, div_zero;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1; op = o; a = x; b = y;
        tick();
        start = 1'b0; op = 3'b110;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        vectors++; if ({busy, done, div_zero} !== 3'b000) begin miscompares++; $display("FAIL reset_flags: got %b expected 000", {busy, done, div_zero}); end
        vectors++; if (hi !== 32'h0) begin miscompares++; $display("FAIL reset_hi: got %h expected 00000000", hi); end
        vectors++; if (lo !== 32'h0) begin miscompares++; $display("FAIL reset_lo: got %h expected 00000000", lo); end
    endtask

    task automatic test_multu();
        int lat;
        issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL multu_busy: got %b expected 1", busy); end
        wait_done(lat);
        vectors++; if (lat != LAT) begin miscompares++; $display("FAIL multu_latency: got %0d expected %0d", lat, LAT); end
        vectors++; if (hi !== 32'hFFFFFFFE) begin miscompares++; $display("FAIL multu_hi: got %h expected fffffffe", hi); end
        vectors++; if (lo !== 32'h00000001) begin miscompares++; $display("FAIL multu_lo: got %h expected 00000001", lo); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL multu_busy_at_done: got %b expected 0", busy); end
        tick();
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL multu_done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_mult_mtxx();
        int lat;
        issue(3'b000, 32'hFFFFFFFD, 32'd7);
        wait_done(lat);
        vectors++; if (lat != LAT) begin miscompares++; $display("FAIL mult_latency: got %0d expected %0d", lat, LAT); end
        vectors++; if (hi !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL mult_hi: got %h expected ffffffff", hi); end
        vectors++; if (lo !== 32'hFFFFFFEB) begin miscompares++; $display("FAIL mult_lo: got %h expected ffffffeb", lo); end
        issue(3'b101, 32'h1234, 32'h0);
        vectors++; if (lo !== 32'h1234) begin miscompares++; $display("FAIL mtlo_lo: got %h expected 00001234", lo); end
        vectors++; if (hi !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL mtlo_hi: got %h expected ffffffff", hi); end
        vectors++; if ({busy, done} !== 2'b00) begin miscompares++; $display("FAIL mtlo_flags: got %b expected 00", {busy, done}); end
        issue(3'b100, 32'hABCD, 32'h0);
        vectors++; if (hi !== 32'hABCD) begin miscompares++; $display("FAIL mthi_hi: got %h expected 0000abcd", hi); end
        issue(3'b110, 32'h5555, 32'h1);
        issue(3'b111, 32'h6666, 32'h2);
        vectors++; if ({hi, lo} !== {32'hABCD, 32'h1234}) begin miscompares++; $display("FAIL noop_hilo: got %h expected 0000abcd00001234", {hi, lo}); end
        vectors++; if ({busy, done} !== 2'b00) begin miscompares++; $display("FAIL noop_flags: got %b expected 00", {busy, done}); end
    endtask

`ifdef MULT_DIV_DIV_EN
    task automatic test_div();
        int lat;
        issue(3'b010, 32'hFFFFFFF9, 32'd2);
        wait_done(lat);
        vectors++; if (lat != LAT) begin miscompares++; $display("FAIL div_latency: got %0d expected %0d", lat, LAT); end
        vectors++; if ({hi, lo} !== {32'hFFFFFFFF, 32'hFFFFFFFD}) begin miscompares++; $display("FAIL div_neg7_2: got %h expected fffffffffffffffd", {hi, lo}); end
        issue(3'b010, 32'h80000000, 32'hFFFFFFFF);
        wait_done(lat);
        vectors++; if ({hi, lo} !== {32'h0, 32'h80000000}) begin miscompares++; $display("FAIL div_overflow: got %h expected 0000000080000000", {hi, lo}); end
        issue(3'b011, 32'd100, 32'd7);
        wait_done(lat);
        vectors++; if ({hi, lo} !== {32'd2, 32'd14}) begin miscompares++; $display("FAIL divu_100_7: got %h expected 000000020000000e", {hi, lo}); end
        vectors++; if (div_zero !== 1'b0) begin miscompares++; $display("FAIL divu_nz_flag: got %b expected 0", div_zero); end
        issue(3'b011, 32'd100, 32'd0);
        wait_done(lat);
        vectors++; if (lat != LAT) begin miscompares++; $display("FAIL divz_latency: got %0d expected %0d", lat, LAT); end
        vectors++; if ({hi, lo} !== {32'd100, 32'hFFFFFFFF}) begin miscompares++; $display("FAIL divz_result: got %h expected 00000064ffffffff", {hi, lo}); end
        vectors++; if (div_zero !== 1'b1) begin miscompares++; $display("FAIL divz_flag: got %b expected 1", div_zero); end
        issue(3'b001, 32'd2, 32'd3);
        vectors++; if (div_zero !== 1'b0) begin miscompares++; $display("FAIL divz_clear: got %b expected 0", div_zero); end
        wait_done(lat);
        vectors++; if ({hi, lo} !== {32'd0, 32'd6}) begin miscompares++; $display("FAIL multu_after_divz: got %h expected 0000000000000006", {hi, lo}); end
    endtask
`else
    task automatic test_div();
        int lat;
        issue(3'b010, 32'hFFFFFFF9, 32'd2);
        vectors++; if ({busy, done, div_zero} !== 3'b001) begin miscompares++; $display("FAIL nodiv_accept: got %b expected 001", {busy, done, div_zero}); end
        tick();
        vectors++; if ({busy, done} !== 2'b01) begin miscompares++; $display("FAIL nodiv_done: got %b expected 01", {busy, done}); end
        vectors++; if ({hi, lo} !== {32'hABCD, 32'h1234}) begin miscompares++; $display("FAIL nodiv_hilo: got %h expected 0000abcd00001234", {hi, lo}); end
        tick();
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL nodiv_pulse: got %b expected 0", done); end
        issue(3'b001, 32'd2, 32'd3);
        vectors++; if (div_zero !== 1'b0) begin miscompares++; $display("FAIL nodiv_clear: got %b expected 0", div_zero); end
        wait_done(lat);
        vectors++; if (lat != LAT) begin miscompares++; $display("FAIL nodiv_mul_latency: got %0d expected %0d", lat, LAT); end
        vectors++; if ({hi, lo} !== {32'd0, 32'd6}) begin miscompares++; $display("FAIL nodiv_multu: got %h expected 0000000000000006", {hi, lo}); end
    endtask
`endif

    task automatic test_back_to_back();
        int lat;
        issue(3'b001, 32'd5, 32'd6);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            start = 1'b1; op = 3'(lat % 8); a = $urandom; b = $urandom;
            tick();
            lat++;
        end
        start = 1'b0; op = 3'b110;
        vectors++; if (lat != LAT) begin miscompares++; $display("FAIL b2b_latency: got %0d expected %0d", lat, LAT); end
        vectors++; if ({hi, lo} !== {32'd0, 32'd30}) begin miscompares++; $display("FAIL b2b_first: got %h expected 000000000000001e", {hi, lo}); end
        issue(3'b001, 32'd7, 32'd9);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_accept: got %b expected 1", busy); end
        wait_done(lat);
        vectors++; if (lat != LAT) begin miscompares++; $display("FAIL b2b_second_latency: got %0d expected %0d", lat, LAT); end
        vectors++; if ({hi, lo} !== {32'd0, 32'd63}) begin miscompares++; $display("FAIL b2b_second: got %h expected 000000000000003f", {hi, lo}); end
    endtask

    task automatic test_reset_mid();
        int lat, pulses;
        issue(3'b100, 32'hCAFE, 32'h0);
        issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (9) tick();
        #3 rst_n = 1'b0;
        #1;
        vectors++; if ({busy, done, div_zero} !== 3'b000) begin miscompares++; $display("FAIL midrst_flags: got %b expected 000", {busy, done, div_zero}); end
        vectors++; if ({hi, lo} !== 64'h0) begin miscompares++; $display("FAIL midrst_hilo: got %h expected 0", {hi, lo}); end
        #2 rst_n = 1'b1;
        pulses = 0;
        repeat (40) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        vectors++; if (pulses != 0) begin miscompares++; $display("FAIL midrst_quiet: got %0d active cycles expected 0", pulses); end
        issue(3'b001, 32'd2, 32'd3);
        wait_done(lat);
        vectors++; if (lat != LAT) begin miscompares++; $display("FAIL midrst_restart_latency: got %0d expected %0d", lat, LAT); end
        vectors++; if ({hi, lo} !== {32'd0, 32'd6}) begin miscompares++; $display("FAIL midrst_restart: got %h expected 0000000000000006", {hi, lo}); end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 3'b110; a = '0; b = '0;
        #22 rst_n = 1'b1;
        tick();
        test_reset();
        test_multu();
        test_mult_mtxx();
        test_div();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
